lap_ctrl: RTL
=============

# lap_ctrl

Sequencing controller for the stopwatch lap memory. It captures the running minutes/seconds value on a lap command and writes it into a circular buffer in the single-port lap BRAM. It arbitrates that port between capture writes, browse reads and a full-memory clear. It sits between the time counter / command decoder and the BRAM, and drives the lap view registers that feed the BCD/hex display path.

## Interface
- `DEPTH`, 16: lap slots in BRAM; power of two, ≥2.
- `ADDR_W`, 4: BRAM address width, equal to log2(DEPTH).
- `DATA_W`, 16: stored word width, always {minutes[7:0], seconds[7:0]}.

- `clk`  in  1  single clock; the stopwatch tick domain.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_lap`  in  1  one-cycle pulse: capture the current time.
- `cmd_next`  in  1  one-cycle pulse: view the next older lap.
- `cmd_prev`  in  1  one-cycle pulse: view the next newer lap.
- `cmd_clear`  in  1  one-cycle pulse: erase all laps.
- `time_s`  in  8  current seconds, binary 0..59.
- `time_m`  in  8  current minutes, binary.
- `mem_we`  out  1  BRAM write enable.
- `mem_adr`  out  ADDR_W  BRAM address.
- `mem_wdata`  out  DATA_W  BRAM write data.
- `mem_rdata`  in  DATA_W  BRAM read data; valid one cycle after the address.
- `view_s`, `view_m`  out  8 each  displayed lap time.
- `view_valid`  out  1  view registers hold a stored lap.
- `lap_count`  out  ADDR_W+1  stored laps, 0..DEPTH.
- `full`  out  1  `lap_count == DEPTH`.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- States: IDLE, WR, RD, RDW, CLR.
- IDLE: commands are accepted with priority clear > lap > next > prev. Simultaneous lower-priority pulses are dropped.
- lap: latch {time_m, time_s}, then go to WR.
- WR: `mem_we`=1, `mem_adr`=`wr_ptr`, `mem_wdata`=latched word.
  - `wr_ptr` advances and wraps DEPTH-1→0.
  - `lap_count` increments and saturates at DEPTH. When full, the oldest lap is overwritten.
  - Next state is IDLE.
- next: if `view_idx+1 < lap_count`, increment `view_idx` and go to RD. Otherwise the command has no effect and the FSM stays in IDLE.
- prev: if `view_idx > 0`, decrement and go to RD. Otherwise no effect.
- A browse command with `lap_count`=0 has no effect.
- `view_idx` 0 is the newest lap. The read address is (`wr_ptr` − 1 − `view_idx`) mod DEPTH.
- RD drives `mem_adr`. RDW loads `view_m`/`view_s` from `mem_rdata`, sets `view_valid`=1, then returns to IDLE.
- CLR: writes 0 to addresses 0..DEPTH-1, one per cycle, using an internal counter. On exit, `wr_ptr`=0, `lap_count`=0, `view_idx`=0, `view_valid`=0 and `view_*`=0.
- While busy: one `cmd_lap` is held in a pending flag and serviced on the next IDLE cycle, ahead of other commands. A second lap while the flag is set is dropped. `cmd_next` and `cmd_prev` are dropped. `cmd_clear` is held pending and takes precedence over a pending lap.
- `mem_we`=0 in every state except WR and CLR.

## Timing
- Reset values: state IDLE; `mem_we`=0, `mem_adr`=0, `mem_wdata`=0; `view_s`=`view_m`=0; `view_valid`=0; `lap_count`=0; `full`=0; `busy`=0; pending flags cleared.
- Lap: pulse at cycle N samples the time at N. `mem_we`=1 at N+1, `lap_count` updates at N+2, and `busy` is high during N+1.
- Browse: pulse at N, `mem_adr` valid at N+1, view registers updated at N+3, `busy` high during N+1..N+2.
- Clear: pulse at N, writes during N+1..N+DEPTH, IDLE at N+DEPTH+1.
- Reset mid-operation, including mid-CLR: abort at once to the reset values. BRAM contents are then undefined, but no stale lap is visible because `lap_count`=0.

## Configuration
- `LAP_CTRL_AUTO_VIEW_EN` defined: WR goes to RD with `view_idx` forced to 0, so the newest lap is displayed 3 cycles after the write cycle.
- Undefined: WR goes to IDLE, and `view_idx` and the view registers are unchanged. When a write does not saturate `lap_count`, `view_idx` is incremented so the lap being viewed stays the same.

## Structure
- Package `lap_pkg`: state enum, `DATA_W` constant, command priority encoding.
- One sub-module, `lap_addr_gen`: combinational read address from `wr_ptr` and `view_idx` with mod-DEPTH wrap. Instantiated once.

## Test plan
- Reset, then lap at time 01:23 → `mem_we`=1 with `mem_adr`=0 and `mem_wdata`=16'h0117. `lap_count`=1.
- 17 laps with DEPTH=16 → `full`=1, `lap_count`=16, 17th write at address 0, `wr_ptr`=1. A next from index 0 reads address 15, i.e. the 16th lap.
- 3 laps (00:05, 00:10, 00:15), then next, next, next → view shows 00:10, then 00:05, then stays at 00:05 with the third next ignored and `busy` low.
- Lap and next asserted in the same cycle → only the write occurs and the view is unchanged (macro undefined).
- Clear issued during RDW → completes after DEPTH write cycles with all addresses 0, `lap_count`=0, `view_valid`=0.
- `rst` asserted at cycle 5 of CLR → next cycle has all outputs at reset values and state IDLE.

Source files
------------

// File: rtl/lap_pkg.sv
// Shared types for the stopwatch lap controller: FSM states, stored word width
// and the command priority encoder.
package lap_pkg;

   localparam int unsigned DATA_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RDW,
      S_CLR
   } lap_state_e;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_CLEAR,
      CMD_LAP,
      CMD_NEXT,
      CMD_PREV
   } lap_cmd_e;

   // Priority: clear > lap > next > prev; lower-priority pulses are dropped.
   function automatic lap_cmd_e lap_cmd_sel(input logic clr, input logic lap,
                                            input logic nxt, input logic prv);
      lap_cmd_e sel;
      if (clr)      sel = CMD_CLEAR;
      else if (lap) sel = CMD_LAP;
      else if (nxt) sel = CMD_NEXT;
      else if (prv) sel = CMD_PREV;
      else          sel = CMD_NONE;
      return sel;
   endfunction

endpackage

// File: rtl/lap_addr_gen.sv
// Browse read address: slot (wr_ptr - 1 - idx) mod DEPTH, combinational.
// DEPTH is a power of two, so the wrap falls out of ADDR_W-bit arithmetic.
module lap_addr_gen #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic [ADDR_W-1:0] wr_ptr_i,
   input  logic [ADDR_W-1:0] idx_i,
   output logic [ADDR_W-1:0] rd_adr_o
);

   // Newest lap sits one slot behind the write pointer.
   assign rd_adr_o = wr_ptr_i - ADDR_W'(1) - idx_i;

endmodule

// File: rtl/lap_ctrl.sv
// Lap memory sequencer: captures {minutes, seconds} into a circular buffer in
// a single-port BRAM, browses stored laps into the view registers and clears
// the whole memory on request.
// Build option: define LAP_CTRL_AUTO_VIEW_EN to show the newest lap right
// after every capture; by default a capture leaves the view untouched.
module lap_ctrl
   import lap_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_lap,
   input  logic              cmd_next,
   input  logic              cmd_prev,
   input  logic              cmd_clear,
   input  logic [7:0]        time_s,
   input  logic [7:0]        time_m,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [7:0]        view_s,
   output logic [7:0]        view_m,
   output logic              view_valid,
   output logic [ADDR_W:0]   lap_count,
   output logic              full,
   output logic              busy
);

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

   lap_state_e        state_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] view_idx_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic [ADDR_W-1:0] mem_adr_q;
   logic [ADDR_W:0]   lap_count_q;
   logic              full_q;
   logic              mem_we_q;
   logic              view_valid_q;
   logic              pend_lap_q;
   logic              pend_clr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] pend_word_q;
   logic [7:0]        view_s_q;
   logic [7:0]        view_m_q;

   lap_cmd_e          cmd_c;
   logic              next_ok_c;
   logic              prev_ok_c;
   logic [ADDR_W-1:0] rd_idx_c;
   logic [ADDR_W-1:0] rd_adr_c;
   logic [DATA_W-1:0] lap_word_c;

   // Command selection in IDLE; pending commands merge with fresh pulses.
   always_comb begin
      cmd_c      = lap_cmd_sel(pend_clr_q | cmd_clear, pend_lap_q | cmd_lap,
                               cmd_next, cmd_prev);
      next_ok_c  = (({1'b0, view_idx_q} + (ADDR_W+1)'(1)) < lap_count_q);
      prev_ok_c  = (view_idx_q != '0);
      lap_word_c = pend_lap_q ? pend_word_q : {time_m, time_s};
      rd_idx_c   = view_idx_q;
      if (cmd_c == CMD_NEXT)      rd_idx_c = view_idx_q + ADDR_W'(1);
      else if (cmd_c == CMD_PREV) rd_idx_c = view_idx_q - ADDR_W'(1);
   end

   lap_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .wr_ptr_i (wr_ptr_q),
      .idx_i    (rd_idx_c),
      .rd_adr_o (rd_adr_c)
   );

   // Sequencer FSM with registered BRAM port and view outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         view_idx_q   <= '0;
         clr_cnt_q    <= '0;
         mem_adr_q    <= '0;
         lap_count_q  <= '0;
         full_q       <= 1'b0;
         mem_we_q     <= 1'b0;
         view_valid_q <= 1'b0;
         pend_lap_q   <= 1'b0;
         pend_clr_q   <= 1'b0;
         mem_wdata_q  <= '0;
         pend_word_q  <= '0;
         view_s_q     <= '0;
         view_m_q     <= '0;
      end else begin
         mem_we_q <= 1'b0;

         // Hold lap/clear pulses that arrive while a sequence is running.
         if (state_q != S_IDLE) begin
            if (cmd_clear) pend_clr_q <= 1'b1;
            if (cmd_lap && !pend_lap_q) begin
               pend_lap_q  <= 1'b1;
               pend_word_q <= {time_m, time_s};
            end
         end

         case (state_q)
            S_IDLE: begin
               case (cmd_c)
                  CMD_CLEAR: begin
                     pend_clr_q  <= 1'b0;
                     clr_cnt_q   <= '0;
                     mem_we_q    <= 1'b1;
                     mem_adr_q   <= '0;
                     mem_wdata_q <= '0;
                     state_q     <= S_CLR;
                  end
                  CMD_LAP: begin
                     pend_lap_q  <= 1'b0;
                     mem_we_q    <= 1'b1;
                     mem_adr_q   <= wr_ptr_q;
                     mem_wdata_q <= lap_word_c;
                     state_q     <= S_WR;
                  end
                  CMD_NEXT: begin
                     if (next_ok_c) begin
                        view_idx_q <= rd_idx_c;
                        mem_adr_q  <= rd_adr_c;
                        state_q    <= S_RD;
                     end
                  end
                  CMD_PREV: begin
                     if (prev_ok_c) begin
                        view_idx_q <= rd_idx_c;
                        mem_adr_q  <= rd_adr_c;
                        state_q    <= S_RD;
                     end
                  end
                  default: ;
               endcase
            end

            S_WR: begin
               wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
               if (lap_count_q != DEPTH_L) begin
                  lap_count_q <= lap_count_q + (ADDR_W+1)'(1);
                  full_q      <= (lap_count_q == (DEPTH_L - (ADDR_W+1)'(1)));
               end
`ifdef LAP_CTRL_AUTO_VIEW_EN
               // mem_adr already points at the slot just written: the newest lap.
               view_idx_q <= '0;
               state_q    <= S_RD;
`else
               // Keep the displayed lap fixed while the newest index shifts.
               if (view_valid_q && (lap_count_q != DEPTH_L))
                  view_idx_q <= view_idx_q + ADDR_W'(1);
               state_q <= S_IDLE;
`endif
            end

            S_RD: begin
               state_q <= S_RDW;
            end

            S_RDW: begin
               view_m_q     <= mem_rdata[DATA_W-1 -: 8];
               view_s_q     <= mem_rdata[7:0];
               view_valid_q <= 1'b1;
               state_q      <= S_IDLE;
            end

            S_CLR: begin
               if (clr_cnt_q == LAST_A) begin
                  wr_ptr_q     <= '0;
                  lap_count_q  <= '0;
                  full_q       <= 1'b0;
                  view_idx_q   <= '0;
                  view_valid_q <= 1'b0;
                  view_s_q     <= '0;
                  view_m_q     <= '0;
                  mem_adr_q    <= '0;
                  state_q      <= S_IDLE;
               end else begin
                  clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                  mem_adr_q <= clr_cnt_q + ADDR_W'(1);
                  mem_we_q  <= 1'b1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_adr    = mem_adr_q;
   assign mem_wdata  = mem_wdata_q;
   assign view_s     = view_s_q;
   assign view_m     = view_m_q;
   assign view_valid = view_valid_q;
   assign lap_count  = lap_count_q;
   assign full       = full_q;
   assign busy       = (state_q != S_IDLE);

endmodule
